mandelbrot_pixel_sink: RTL and testbench

Downstream stage of the Mandelbrot engine. Paces the engine one pixel at a time via its run/running handshake and captures each 4-bit iteration result. Packs two pixels per byte into a small FIFO and presents a valid/ready byte stream to the output/host interface. Stops issuing pixels when the FIFO has no room, so the engine is back-pressured rather than losing data.

---
 rtl/mandelbrot_pkg.sv | 22 ++
 rtl/mandelbrot_sink_fifo.sv | 66 ++++++
 rtl/mandelbrot_pixel_sink.sv | 168 ++++++++++++++++
 tb/tb_mandelbrot_pixel_sink.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg
// Shared types and constants for the Mandelbrot pixel sink.
//   sink_state_t : state encoding of the pixel-pacing FSM
//   PIX_BITS     : width of one iteration result (one pixel)
//   count_width  : width of a counter that must reach WIDTH*HEIGHT
package mandelbrot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } sink_state_t;

  localparam int PIX_BITS = 4;

  function automatic int count_width(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction

endpackage

// File: rtl/mandelbrot_sink_fifo.sv
// mandelbrot_sink_fifo
// Synchronous first-word-fall-through FIFO holding packed pixel bytes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (contents discarded)
//   wr_en       : write request, wr_data captured on the clock edge
//   wr_data     : entry to store
//   rd_en       : consumer pop; only honoured while valid is high
//   rd_data     : head entry (mem[rd_ptr]), meaningful while valid is high
//   valid       : FIFO holds at least one entry
//   count       : number of stored entries, 0..DEPTH
module mandelbrot_sink_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_rd;
  logic              do_wr;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a write.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && ((count != FULL) || do_rd);

  assign rd_data = mem[rd_ptr];
  assign valid   = (count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// mandelbrot_pixel_sink
// Paces the Mandelbrot engine one pixel at a time, packs two 4-bit results
// per byte into a FWFT FIFO and streams the bytes out over valid/ready.
// A pixel is only issued when the FIFO has a free slot, so the engine is
// back-pressured instead of losing data.
// Optional feature macro: MANDEL_SINK_EOL_EN adds out_last, marking the byte
// that holds pixel x = WIDTH-1 of each line.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : pulse, begins a frame when idle
//   busy             : frame in progress
//   frame_done       : pulse after the last pixel is captured
//   protocol_err     : sticky, engine_finished disagrees with the pixel count
//   engine_run       : one-cycle run request to the engine
//   engine_running   : engine busy flag
//   engine_ctr       : engine iteration result
//   engine_finished  : engine end-of-frame flag
//   out_data         : packed pixels, [3:0] even x, [7:4] odd x
//   out_valid        : out_data valid
//   out_ready        : consumer accepts a byte when out_valid && out_ready
//   out_last         : (MANDEL_SINK_EOL_EN only) byte ends a line
module mandelbrot_pixel_sink
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  output logic                protocol_err,
  output logic                engine_run,
  input  logic                engine_running,
  input  logic [PIX_BITS-1:0] engine_ctr,
  input  logic                engine_finished,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready
`ifdef MANDEL_SINK_EOL_EN
  ,
  output logic                out_last
`endif
);

  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int CNT_W  = count_width(WIDTH, HEIGHT);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(TOTAL - 1);
`ifdef MANDEL_SINK_EOL_EN
  localparam int ENTRY_W = 9;
  localparam int X_W     = $clog2(WIDTH);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
`else
  localparam int ENTRY_W = 8;
`endif

  sink_state_t         state;
  sink_state_t         state_next;
  logic [CNT_W-1:0]    pix_cnt;
  logic [PIX_BITS-1:0] nibble;
  logic [FCNT_W-1:0]   fifo_count;
  logic                capture;
  logic                fifo_wr;
  logic [ENTRY_W-1:0]  fifo_wdata;
  logic [ENTRY_W-1:0]  fifo_rdata;

  // The result is valid on the cycle running falls while we wait for it.
  assign capture = (state == WAIT_LO) && !engine_running;
  assign fifo_wr = capture && pix_cnt[0];

`ifdef MANDEL_SINK_EOL_EN
  logic [X_W-1:0] x_cnt;

  assign fifo_wdata = {(x_cnt == X_LAST), engine_ctr, nibble};
  assign {out_last, out_data} = fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
    end else if (state == DONE) begin
      x_cnt <= '0;
    end else if (capture) begin
      x_cnt <= (x_cnt == X_LAST) ? '0 : x_cnt + X_W'(1);
    end
  end
`else
  assign fifo_wdata = {engine_ctr, nibble};
  assign out_data   = fifo_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only one pixel is ever outstanding, so checking for a free slot before
  // issuing guarantees the capture write always fits.
  always_comb begin
    state_next = state;
    engine_run = 1'b0;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE: begin
        if (fifo_count < FIFO_FULL) begin
          engine_run = 1'b1;
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: if (engine_running) state_next = WAIT_LO;
      WAIT_LO: begin
        if (!engine_running) begin
          state_next = (pix_cnt == LAST_IDX) ? DONE : ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // pix_cnt counts captured pixels; while waiting for pixel n it holds n, so
  // an early finish is any finish seen before the last pixel is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt      <= '0;
      nibble       <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (state == DONE) begin
        pix_cnt <= '0;
      end else if (capture) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
        if (!pix_cnt[0]) begin
          nibble <= engine_ctr;
        end
      end
      if ((state == WAIT_LO) && engine_finished && (pix_cnt < LAST_IDX)) begin
        protocol_err <= 1'b1;
      end
      if (capture && (pix_cnt == LAST_IDX) && !engine_finished) begin
        protocol_err <= 1'b1;
      end
    end
  end

  mandelbrot_sink_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (out_ready),
    .rd_data (fifo_rdata),
    .valid   (out_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// tb_mandelbrot_pixel_sink
// Scoreboard bench: each accepted start pushes the frame's expected packed
// bytes into a queue; a monitor pops and compares on every out handshake.
// A behavioural engine takes 3 cycles per pixel and returns the pixel value
// chosen by the bench for that index.
module tb_mandelbrot_pixel_sink;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int D     = 2;
  localparam int TOTAL = W * H;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic       protocol_err;
  logic       engine_run;
  logic       engine_running;
  logic [3:0] engine_ctr;
  logic       engine_finished;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef MANDEL_SINK_EOL_EN
  logic       out_last;
`endif

  mandelbrot_pixel_sink #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .frame_done      (frame_done),
    .protocol_err    (protocol_err),
    .engine_run      (engine_run),
    .engine_running  (engine_running),
    .engine_ctr      (engine_ctr),
    .engine_finished (engine_finished),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
`ifdef MANDEL_SINK_EOL_EN
    ,
    .out_last        (out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         run_cnt = 0;
  int         byte_cnt = 0;
  int         ready_mode = 1;
  bit         inject_early = 1'b0;
  logic [3:0] frame_pix [TOTAL];
  logic [8:0] exp_q [$];

  int eng_idx;
  int eng_left;

  // Behavioural engine: run starts a 3-cycle computation, result appears as
  // running falls; finished marks the last pixel of the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      engine_running  <= 1'b0;
      engine_ctr      <= 4'h0;
      engine_finished <= 1'b0;
      eng_idx         <= 0;
      eng_left        <= 0;
    end else if (engine_run) begin
      engine_running  <= 1'b1;
      engine_finished <= 1'b0;
      eng_left        <= 3;
    end else if (engine_running) begin
      if (eng_left == 1) begin
        engine_running  <= 1'b0;
        engine_ctr      <= frame_pix[eng_idx];
        engine_finished <= (eng_idx == TOTAL - 1) || (inject_early && eng_idx == 3);
        eng_idx         <= (eng_idx == TOTAL - 1) ? 0 : eng_idx + 1;
      end else begin
        eng_left <= eng_left - 1;
      end
    end
  end

  // Consumer side: ready is changed just after the rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts events and pops the scoreboard on each accepted byte.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_done) done_cnt++;
        if (engine_run) run_cnt++;
        if (out_valid && out_ready) begin
          byte_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("byte", {24'h0, out_data}, {24'h0, e[7:0]});
`ifdef MANDEL_SINK_EOL_EN
            checkOutput("out_last", {31'h0, out_last}, {31'h0, e[8]});
`endif
          end
        end
      end
    end
  end

  // Reference: byte k holds pixels 2k (low) and 2k+1 (high); it ends a line
  // when pixel 2k+1 sits in the last column.
  task automatic pushFrame();
    for (int k = 0; k < TOTAL / 2; k++) begin
      exp_q.push_back({((2 * k + 1) % W == W - 1), frame_pix[2 * k + 1], frame_pix[2 * k]});
    end
  endtask

  // pattern: 0 = pixel index, 1 = random. An ignored start keeps the frame.
  task automatic applyStimulus(input int pattern, input bit accepted);
    if (accepted) begin
      for (int i = 0; i < TOTAL; i++) begin
        frame_pix[i] = (pattern == 0) ? 4'(i) : 4'($urandom_range(0, 15));
      end
      pushFrame();
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: frame_done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: %0d bytes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checkOutput({name, "_empty"}, {31'h0, out_valid}, 32'h0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #2;
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, frame_done}, 32'h0);
    checkOutput("rst_err", {31'h0, protocol_err}, 32'h0);
    checkOutput("rst_run", {31'h0, engine_run}, 32'h0);
    checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_data", {24'h0, out_data}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    int r0;
    int b0;
    int i;
    rst_n = 1'b1;
    start = 1'b0;
    for (int k = 0; k < TOTAL; k++) frame_pix[k] = 4'h0;

    doReset();

    // Nominal frame: 0x10 0x32 0x54 0x76
    $display("[TB] nominal frame");
    ready_mode = 1;
    d0 = done_cnt;
    applyStimulus(0, 1'b1);
    waitDone(d0, 200, "nominal_done");
    drain(50, "nominal_drain");
    checkOutput("nominal_busy", {31'h0, busy}, 32'h0);
    checkOutput("nominal_err", {31'h0, protocol_err}, 32'h0);
    checkOutput("nominal_done_cnt", done_cnt - d0, 1);

    // Backpressure: engine must stall after filling the FIFO
    $display("[TB] backpressure");
    ready_mode = 0;
    d0 = done_cnt;
    r0 = run_cnt;
    b0 = byte_cnt;
    applyStimulus(0, 1'b1);
    repeat (60) @(negedge clk);
    checkOutput("bp_runs", run_cnt - r0, 4);
    checkOutput("bp_busy", {31'h0, busy}, 32'h1);
    checkOutput("bp_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("bp_run_low", {31'h0, engine_run}, 32'h0);
    checkOutput("bp_bytes", byte_cnt - b0, 0);
    ready_mode = 1;
    waitDone(d0, 200, "bp_done");
    drain(50, "bp_drain");
    checkOutput("bp_total_bytes", byte_cnt - b0, 4);
    checkOutput("bp_busy_after", {31'h0, busy}, 32'h0);

    // Start while busy is ignored
    $display("[TB] start while busy");
    d0 = done_cnt;
    b0 = byte_cnt;
    applyStimulus(0, 1'b1);
    repeat (7) @(negedge clk);
    applyStimulus(0, 1'b0);
    waitDone(d0, 200, "sb_done");
    repeat (30) @(negedge clk);
    drain(50, "sb_drain");
    checkOutput("sb_done_cnt", done_cnt - d0, 1);
    checkOutput("sb_bytes", byte_cnt - b0, 4);
    checkOutput("sb_busy", {31'h0, busy}, 32'h0);

    // Early engine_finished raises a sticky error
    $display("[TB] protocol error");
    inject_early = 1'b1;
    d0 = done_cnt;
    applyStimulus(0, 1'b1);
    waitDone(d0, 200, "pe_done");
    drain(50, "pe_drain");
    inject_early = 1'b0;
    checkOutput("pe_err", {31'h0, protocol_err}, 32'h1);
    repeat (10) @(negedge clk);
    checkOutput("pe_err_held", {31'h0, protocol_err}, 32'h1);
    doReset();

    // Reset mid-frame after two bytes
    $display("[TB] reset mid-frame");
    b0 = byte_cnt;
    applyStimulus(0, 1'b1);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_cnt - b0 >= 2) break;
    end
    if (i == 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL mr_bytes: only %0d bytes, expected 2", byte_cnt - b0);
    end
    doReset();
    d0 = done_cnt;
    applyStimulus(0, 1'b1);
    waitDone(d0, 200, "mr_done");
    drain(50, "mr_drain");

    // Randomized frames with random consumer readiness
    $display("[TB] random frames");
    for (int f = 0; f < 5; f++) begin
      ready_mode = 2;
      d0 = done_cnt;
      applyStimulus(1, 1'b1);
      waitDone(d0, 400, "rnd_done");
      ready_mode = 1;
      drain(100, "rnd_drain");
      checkOutput("rnd_err", {31'h0, protocol_err}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
